// File: rtl/uart_frame_if.sv
// Byte stream from the UART receiver into the frame decoder, plus the decoded
// payload and status strobes going back out.
interface uart_frame_if #(
  parameter int unsigned DW = 32
) ();
  logic          uart_rx_done;
  logic [7:0]    uart_rx_data;
  logic [DW-1:0] data_out;
  logic          uart_done;
  logic          frame_err;

  // master: byte source / payload consumer; slave: the frame decoder
  modport master (
    output uart_rx_done, uart_rx_data,
    input  data_out, uart_done, frame_err
  );

  modport slave (
    input  uart_rx_done, uart_rx_data,
    output data_out, uart_done, frame_err
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Header-hunting UART frame decoder: HDR0 HDR1, NUM_CH x CH_BYTES little-endian payload,
// committed atomically to data_out. Define UART_FRAME_CKSUM_EN to require a trailing sum byte.
module uart_frame_decoder #(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned CH_BYTES    = 4,
  parameter logic [7:0]  HDR0        = 8'h4B,
  parameter logic [7:0]  HDR1        = 8'h4C,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic       clk_50m,
  input logic       rst,
  uart_frame_if.slave bus
);

  localparam int unsigned NB    = NUM_CH * CH_BYTES;
  localparam int unsigned DW    = NB * 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned GAP_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(TIMEOUT_CYC);

`ifdef UART_FRAME_CKSUM_EN
  typedef enum logic [2:0] {HUNT0, HUNT1, PAYLOAD, CKSUM, COMMIT} state_e;
`else
  typedef enum logic [2:0] {HUNT0, HUNT1, PAYLOAD, COMMIT} state_e;
`endif

  state_e           state_q, state_d;
  logic             done_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [DW-1:0]    shadow_q, shadow_d;
  logic [DW-1:0]    data_q, data_d;
  logic             uart_done_q, uart_done_d;
  logic             frame_err_q, frame_err_d;
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic rx_pos;
  logic timed;
  logic timeout;

  assign rx_pos = bus.uart_rx_done & ~done_q;

  always_comb begin
    timed = (state_q == HUNT1) || (state_q == PAYLOAD);
`ifdef UART_FRAME_CKSUM_EN
    timed = timed || (state_q == CKSUM);
`endif
  end

  // A strobe landing on the terminal count wins over the timeout.
  assign timeout = (TIMEOUT_CYC != 0) && timed && (gap_q == GAP_END) && !rx_pos;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    uart_done_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
    sum_d       = sum_q;
`endif

    if (timeout) begin
      state_d     = HUNT0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        HUNT0: begin
          if (rx_pos && bus.uart_rx_data == HDR0) state_d = HUNT1;
        end
        HUNT1: begin
          if (rx_pos) begin
            if (bus.uart_rx_data == HDR1) begin
              idx_d   = '0;
`ifdef UART_FRAME_CKSUM_EN
              sum_d   = 8'h00;
`endif
              state_d = PAYLOAD;
            end else if (bus.uart_rx_data != HDR0) begin
              state_d = HUNT0;
            end
          end
        end
        PAYLOAD: begin
          if (rx_pos) begin
            for (int i = 0; i < int'(NB); i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i*8 +: 8] = bus.uart_rx_data;
            end
`ifdef UART_FRAME_CKSUM_EN
            sum_d = sum_q + bus.uart_rx_data;
`endif
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
`ifdef UART_FRAME_CKSUM_EN
              state_d = CKSUM;
`else
              state_d = COMMIT;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
`ifdef UART_FRAME_CKSUM_EN
        CKSUM: begin
          if (rx_pos) begin
            if (bus.uart_rx_data == sum_q) begin
              state_d = COMMIT;
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT0;
            end
          end
        end
`endif
        COMMIT: begin
          data_d      = shadow_q;
          uart_done_d = 1'b1;
          state_d     = HUNT0;
        end
        default: state_d = HUNT0;
      endcase
    end

    // Gap counter restarts on every byte and on every state change.
    if (TIMEOUT_CYC == 0 || !timed || rx_pos || state_d != state_q) gap_d = '0;
    else                                                           gap_d = gap_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      // NOTE: payload registers are plain flops and are cleared on reset along with control state.
      state_q     <= HUNT0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      gap_q       <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      uart_done_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= bus.uart_rx_done;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      uart_done_q <= uart_done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_FRAME_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.uart_done = uart_done_q;
  assign bus.frame_err = frame_err_q;

endmodule
